// File: rtl/mutual_system_param_if.sv
// Rule-select / observability bundle for mutual_system_param.
// master drives the rule select; slave (the DUT) returns registered state and flags.
interface mutual_system_param_if #(
    parameter int unsigned NUM_CLIENTS = 3,
    parameter int unsigned CNT_W       = 8
);
    localparam int unsigned RULE_W = $clog2(4 * NUM_CLIENTS + 1);
    localparam int unsigned N_W    = 2 * NUM_CLIENTS;

    logic              io_valid;
    logic [RULE_W-1:0] io_en_a;
    logic [N_W-1:0]    io_n;
    logic              io_x;
    logic              io_fired;
    logic [CNT_W-1:0]  io_crit_cnt;
    logic              io_inv_err;

    modport master (
        output io_valid, io_en_a,
        input  io_n, io_x, io_fired, io_crit_cnt, io_inv_err
    );

    modport slave (
        input  io_valid, io_en_a,
        output io_n, io_x, io_fired, io_crit_cnt, io_inv_err
    );
endinterface

// File: rtl/mutual_system_param.sv
// N-client I/T/C/E mutual-exclusion system sharing one flag x; one guarded rule per cycle.
// Optional sticky invariant checker enabled by defining MUTUAL_INV_CHECK_EN.
module mutual_system_param #(
    parameter int unsigned NUM_CLIENTS = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    mutual_system_param_if.slave  bus
);
    localparam int unsigned RULE_W    = $clog2(4 * NUM_CLIENTS + 1);
    localparam int unsigned CL_W      = RULE_W - 2;
    localparam int unsigned NUM_RULES = 4 * NUM_CLIENTS;

    typedef enum logic [1:0] {
        ST_I = 2'b00,
        ST_T = 2'b01,
        ST_C = 2'b10,
        ST_E = 2'b11
    } client_state_e;

    typedef enum logic [1:0] {
        RK_TRY  = 2'b00,
        RK_CRIT = 2'b01,
        RK_EXIT = 2'b10,
        RK_IDLE = 2'b11
    } rule_kind_e;

    logic [NUM_CLIENTS-1:0][1:0] n_q, n_d;
    logic                        x_q, x_d;
    logic                        fired_q, fired_d;
    logic [CNT_W-1:0]            crit_cnt_q, crit_cnt_d;
    logic                        inv_err_q, inv_err_d;

    logic [CL_W-1:0] sel_client;
    rule_kind_e      sel_kind;
    logic            sel_in_range;

    // Rule index splits into client (idx/4) and rule kind (idx%4).
    always_comb begin
        sel_client   = bus.io_en_a[RULE_W-1:2];
        sel_kind     = rule_kind_e'(bus.io_en_a[1:0]);
        sel_in_range = 32'(bus.io_en_a) < NUM_RULES;
    end

    // Next-state: fire the selected rule only when its guard holds.
    always_comb begin
        n_d        = n_q;
        x_d        = x_q;
        crit_cnt_d = crit_cnt_q;
        fired_d    = 1'b0;
        if (bus.io_valid && sel_in_range) begin
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (sel_client == CL_W'(i)) begin
                    unique case (sel_kind)
                        RK_TRY: begin
                            if (client_state_e'(n_q[i]) == ST_I) begin
                                n_d[i]  = ST_T;
                                fired_d = 1'b1;
                            end
                        end
                        RK_CRIT: begin
                            if (client_state_e'(n_q[i]) == ST_T && x_q) begin
                                n_d[i]  = ST_C;
                                x_d     = 1'b0;
                                fired_d = 1'b1;
                                if (crit_cnt_q != {CNT_W{1'b1}}) begin
                                    crit_cnt_d = crit_cnt_q + CNT_W'(1);
                                end
                            end
                        end
                        RK_EXIT: begin
                            if (client_state_e'(n_q[i]) == ST_C) begin
                                n_d[i]  = ST_E;
                                fired_d = 1'b1;
                            end
                        end
                        RK_IDLE: begin
                            if (client_state_e'(n_q[i]) == ST_E) begin
                                n_d[i]  = ST_I;
                                x_d     = 1'b1;
                                fired_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef MUTUAL_INV_CHECK_EN
    localparam int unsigned CC_W = $clog2(NUM_CLIENTS + 1);

    logic [CC_W-1:0] c_count;
    logic            inv_viol_c;

    // Violation: more than one client critical, or a critical client while x is free.
    always_comb begin
        c_count = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (client_state_e'(n_q[i]) == ST_C) begin
                c_count = c_count + CC_W'(1);
            end
        end
        inv_viol_c = (c_count > CC_W'(1)) || ((c_count != '0) && x_q);
        inv_err_d  = inv_err_q | inv_viol_c;
    end

`ifdef FORMAL
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!inv_viol_c);
        end
    end
`endif
`else
    assign inv_err_d = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            n_q        <= '0;
            x_q        <= 1'b1;
            fired_q    <= 1'b0;
            crit_cnt_q <= '0;
            inv_err_q  <= 1'b0;
        end else begin
            n_q        <= n_d;
            x_q        <= x_d;
            fired_q    <= fired_d;
            crit_cnt_q <= crit_cnt_d;
            inv_err_q  <= inv_err_d;
        end
    end

    assign bus.io_n        = n_q;
    assign bus.io_x        = x_q;
    assign bus.io_fired    = fired_q;
    assign bus.io_crit_cnt = crit_cnt_q;
    assign bus.io_inv_err  = inv_err_q;
endmodule
